// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared event/state types for button_event_ctrl (option: BTN_AUTOREPEAT_EN)
package btn_pkg;

   typedef enum logic [1:0] {
      PRESS   = 2'd0,
      RELEASE = 2'd1,
      LONG    = 2'd2,
      REPEAT  = 2'd3
   } evt_kind_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      LONGHELD = 2'd2
   } btn_state_t;

   localparam int EVT_W = 2;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - per-button hold FSM, counters and one-entry pending slot
// BTN_AUTOREPEAT_EN adds a repeat counter and REPEAT events while long-held.
module btn_channel
   import btn_pkg::*;
#(
   parameter int LONG_CYC = 50_000_000,
   parameter int REP_CYC  = 10_000_000
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      db_i,
   input  logic      grant_i,
   output logic      pend_o,
   output evt_kind_t kind_o,
   output logic      drop_o
);

   localparam int CW = $clog2(LONG_CYC + 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   btn_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pend_q, pend_d;
   evt_kind_t       kind_q, kind_d;
   logic            gen;
   evt_kind_t       gen_kind;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REP_CYC + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REP_CYC - 1);
   logic [RW-1:0]   rcnt_q, rcnt_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gen      = 1'b0;
      gen_kind = PRESS;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_d   = rcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (db_i) begin
               state_d  = HELD;
               cnt_d    = '0;
               gen      = 1'b1;
               gen_kind = PRESS;
            end
         end
         HELD: begin
            if (!db_i) begin
               state_d  = IDLE;
               gen      = 1'b1;
               gen_kind = RELEASE;
            end else if (cnt_q == LONG_LAST) begin
               state_d  = LONGHELD;
               cnt_d    = '0;
               gen      = 1'b1;
               gen_kind = LONG;
`ifdef BTN_AUTOREPEAT_EN
               rcnt_d   = '0;
`endif
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LONGHELD: begin
            if (!db_i) begin
               state_d  = IDLE;
               gen      = 1'b1;
               gen_kind = RELEASE;
`ifdef BTN_AUTOREPEAT_EN
            end else if (rcnt_q == REP_LAST) begin
               rcnt_d   = '0;
               gen      = 1'b1;
               gen_kind = REPEAT;
            end else begin
               rcnt_d = rcnt_q + RW'(1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A grant frees the slot this cycle, so a same-cycle event may take it.
      pend_d = pend_q;
      kind_d = kind_q;
      drop_o = 1'b0;
      if (gen) begin
         if (!pend_q || grant_i) begin
            pend_d = 1'b1;
            kind_d = gen_kind;
         end else begin
            drop_o = 1'b1;
         end
      end else if (grant_i) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         kind_q  <= PRESS;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         kind_q  <= kind_d;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_q  <= rcnt_d;
`endif
      end
   end

   assign pend_o = pend_q;
   assign kind_o = kind_q;

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - button event generator with round-robin event output
// Auto-repeat events are compiled in when BTN_AUTOREPEAT_EN is defined.
module button_event_ctrl
   import btn_pkg::*;
#(
   parameter int NBTN     = 4,
   parameter int LONG_CYC = 50_000_000,
   parameter int REP_CYC  = 10_000_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NBTN-1:0]         db,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(NBTN)-1:0] evt_btn,
   output logic [EVT_W-1:0]        evt_kind,
   output logic                    overflow,
   input  logic                    ovf_clr
);

   localparam int BW = $clog2(NBTN);

   logic [NBTN-1:0] pend, grant, drop;
   evt_kind_t       ch_kind [NBTN];

   logic            valid_q, valid_d;
   logic [BW-1:0]   btn_q, btn_d;
   evt_kind_t       kind_q, kind_d;
   logic [BW-1:0]   ptr_q, ptr_d;
   logic            ovf_q, ovf_d;
   logic            can_grant, gnt_found;
   logic [BW-1:0]   gnt_idx, j_idx;
   int              j;

   for (genvar i = 0; i < NBTN; i++) begin : g_ch
      btn_channel #(
         .LONG_CYC (LONG_CYC),
         .REP_CYC  (REP_CYC)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .db_i    (db[i]),
         .grant_i (grant[i]),
         .pend_o  (pend[i]),
         .kind_o  (ch_kind[i]),
         .drop_o  (drop[i])
      );
   end

   always_comb begin
      can_grant = !valid_q || evt_ready;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      j_idx     = '0;
      // Scan starts at the pointer and wraps, so the first hit is the RR winner.
      for (int i = 0; i < NBTN; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NBTN) j = j - NBTN;
         j_idx = BW'(j);
         if (can_grant && !gnt_found && pend[j_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = j_idx;
         end
      end

      grant = '0;
      if (gnt_found) grant[gnt_idx] = 1'b1;

      valid_d = valid_q;
      btn_d   = btn_q;
      kind_d  = kind_q;
      ptr_d   = ptr_q;
      if (gnt_found) begin
         valid_d = 1'b1;
         btn_d   = gnt_idx;
         kind_d  = ch_kind[gnt_idx];
         ptr_d   = (gnt_idx == BW'(NBTN - 1)) ? '0 : gnt_idx + BW'(1);
      end else if (evt_ready) begin
         valid_d = 1'b0;
      end

      if (|drop)        ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         btn_q   <= '0;
         kind_q  <= PRESS;
         ptr_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         btn_q   <= btn_d;
         kind_q  <= kind_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_btn   = btn_q;
   assign evt_kind  = kind_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - self-checking bench for button_event_ctrl (honours BTN_AUTOREPEAT_EN)
module tb_button_event_ctrl;

   localparam int N  = 4;
   localparam int LC = 8;
   localparam int RC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] db = 4'b0000;
   logic       evt_ready = 1'b1;
   logic       ovf_clr = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_btn;
   logic [1:0] evt_kind;
   logic       overflow;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   button_event_ctrl #(
      .NBTN     (N),
      .LONG_CYC (LC),
      .REP_CYC  (RC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .db        (db),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn),
      .evt_kind  (evt_kind),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   // Behavioural model: hold time since press, pending slots, RR pointer, output.
   bit m_held [N];
   int m_hcnt [N];
   bit m_pend [N];
   int m_pk   [N];
   bit m_has  [N];
   int m_ev   [N];
   int m_ptr = 0;
   bit m_ov  = 0;
   int m_ob  = 0;
   int m_ok  = 0;
   bit m_ovf = 0;
   int m_g;
   bit m_drop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < N; b++) begin
            m_held[b] = 0; m_hcnt[b] = 0; m_pend[b] = 0; m_pk[b] = 0;
         end
         m_ptr = 0; m_ov = 0; m_ob = 0; m_ok = 0; m_ovf = 0;
      end else begin
         for (int b = 0; b < N; b++) begin
            m_has[b] = 0;
            m_ev[b]  = 0;
            if (!m_held[b] && db[b]) begin
               m_held[b] = 1; m_hcnt[b] = 0; m_has[b] = 1; m_ev[b] = 0;
            end else if (m_held[b] && !db[b]) begin
               m_held[b] = 0; m_has[b] = 1; m_ev[b] = 1;
            end else if (m_held[b]) begin
               m_hcnt[b] = m_hcnt[b] + 1;
               if (m_hcnt[b] == LC) begin
                  m_has[b] = 1; m_ev[b] = 2;
               end
`ifdef BTN_AUTOREPEAT_EN
               if (m_hcnt[b] > LC && (m_hcnt[b] - LC) % RC == 0) begin
                  m_has[b] = 1; m_ev[b] = 3;
               end
`endif
            end
         end
         m_g = -1;
         if (!m_ov || evt_ready) begin
            for (int k = 0; k < N; k++) begin
               if (m_g < 0 && m_pend[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
         end
         if (m_g >= 0) begin
            m_ov = 1; m_ob = m_g; m_ok = m_pk[m_g]; m_ptr = (m_g + 1) % N;
         end else if (m_ov && evt_ready) begin
            m_ov = 0;
         end
         m_drop = 0;
         for (int b = 0; b < N; b++) begin
            if (m_has[b]) begin
               if (!m_pend[b] || m_g == b) begin
                  m_pend[b] = 1; m_pk[b] = m_ev[b];
               end else begin
                  m_drop = 1;
               end
            end else if (m_g == b) begin
               m_pend[b] = 0;
            end
         end
         if (m_drop)       m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      chk("model_valid", int'(evt_valid), int'(m_ov));
      if (m_ov) begin
         chk("model_btn", int'(evt_btn), m_ob);
         chk("model_kind", int'(evt_kind), m_ok);
      end
      chk("model_ovf", int'(overflow), int'(m_ovf));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string nm, input int v, input int b, input int k, input int o);
      chk({nm, "_valid"}, int'(evt_valid), v);
      if (v != 0) begin
         chk({nm, "_btn"}, int'(evt_btn), b);
         chk({nm, "_kind"}, int'(evt_kind), k);
      end
      chk({nm, "_ovf"}, int'(overflow), o);
   endtask

   initial begin
      step(3);
      lit("reset", 0, 0, 0, 0);
      chk("reset_btn", int'(evt_btn), 0);
      chk("reset_kind", int'(evt_kind), 0);
      rst_n = 1'b1;
      step(2);

      // simultaneous presses on 0 and 3, then simultaneous releases
      db = 4'b1001;
      step(2); lit("pair_press0", 1, 0, 0, 0);
      step(1); lit("pair_press3", 1, 3, 0, 0);
      db = 4'b0000;
      step(2); lit("pair_rel0", 1, 0, 1, 0);
      step(1); lit("pair_rel3", 1, 3, 1, 0);
      step(3);

      // short press on button 2
      db = 4'b0100;
      step(2); lit("short_press", 1, 2, 0, 0);
      step(1); db = 4'b0000;
      step(2); lit("short_rel", 1, 2, 1, 0);
      step(8); lit("short_idle", 0, 0, 0, 0);

      // long hold on button 1
      db = 4'b0010;
      step(2); lit("long_press", 1, 1, 0, 0);
      step(8); lit("long_long", 1, 1, 2, 0);
      step(4);
`ifdef BTN_AUTOREPEAT_EN
      lit("long_repeat", 1, 1, 3, 0);
`else
      lit("long_norepeat", 0, 0, 0, 0);
`endif
      step(6); db = 4'b0000;
      step(2); lit("long_rel", 1, 1, 1, 0);
      step(3);

      // backpressure and overflow on button 1
      evt_ready = 1'b0;
      db = 4'b0010;
      step(1); db = 4'b0000;
      step(1); lit("bp_press", 1, 1, 0, 0); db = 4'b0010;
      step(1); lit("bp_drop", 1, 1, 0, 1); db = 4'b0000;
      step(3); lit("bp_stable", 1, 1, 0, 1);
      ovf_clr = 1'b1;
      step(1); ovf_clr = 1'b0; lit("bp_clr", 1, 1, 0, 0);
      db = 4'b0010; ovf_clr = 1'b1;
      step(1); ovf_clr = 1'b0; lit("bp_setwins", 1, 1, 0, 1);
      db = 4'b0000; evt_ready = 1'b1;
      step(5); ovf_clr = 1'b1;
      step(1); ovf_clr = 1'b0; lit("bp_final", 0, 0, 0, 0);

      // asynchronous reset with events in flight
      evt_ready = 1'b0;
      db = 4'b0110;
      step(2);
      #2 rst_n = 1'b0;
      #1 lit("rst_async", 0, 0, 0, 0);
      chk("rst_async_btn", int'(evt_btn), 0);
      chk("rst_async_kind", int'(evt_kind), 0);
      db = 4'b0100;
      step(2);
      rst_n = 1'b1; evt_ready = 1'b1;
      step(2); lit("rst_press", 1, 2, 0, 0);
      step(6); lit("rst_idle", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
